fft_bitrev_reorder: RTL and testbench
=====================================

// Module: fft_bitrev_reorder
// PURPOSE
//  Output end of the 32-point pipelined FFT. Accepts the last stage's bit-reversed-order stream (valid_i, data_in_r/i)
//  and re-emits each 32-sample frame in natural order (X[0]..X[31]) as a contiguous 32-cycle burst.
//  Ping-pong buffer: one bank fills while the other drains, so frames arriving back-to-back at 1 sample/cycle never stall.
// PARAMETERS
//  DATA_W  19  width of each real/imag sample (two's complement, passed through unchanged)
//  N       32  points per frame (power of two)
//  LOG2N   5   log2(N); address/counter width
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous active-low reset
//  valid_i     in   1        data_in_* holds an FFT output sample this cycle
//  data_in_r   in   DATA_W   real part, bit-reversed frame order
//  data_in_i   in   DATA_W   imag part
//  valid_o     out  1        data_out_* valid (registered)
//  data_out_r  out  DATA_W   real part, natural order
//  data_out_i  out  DATA_W   imag part, natural order
//  last_o      out  1        high with the X[N-1] output of each frame
// BEHAVIOUR
//  Reset (rst=0, async): valid_o=0, last_o=0, data_out_r/i=0, wr_cnt=0, wr_bank=0, rd FSM=IDLE, full[1:0]=0.
//   Buffer RAM contents are not reset. A partial frame in progress at reset is discarded; an in-progress drain is aborted.
//  Write side: on valid_i=1, store {data_in_r,data_in_i} in bank wr_bank at address bitrev(wr_cnt); wr_cnt++ (mod N).
//   valid_i=0 holds wr_cnt; gaps of any length inside a frame are allowed.
//   When wr_cnt==N-1 is accepted: wr_cnt wraps to 0, full[wr_bank] set, wr_bank toggles.
//  Read FSM:
//   IDLE: if full[b] for bank b (the older bank if both full) -> DRAIN on b, rd_cnt=0.
//   DRAIN: each cycle read address rd_cnt of bank b; register it to data_out_*; valid_o=1; rd_cnt++.
//    At rd_cnt==N-1: last_o=1, clear full[b]; then go to DRAIN on the other bank if that bank is full, else to IDLE.
//    The next drain is back-to-back, with no idle cycle.
//  Latency: the 32nd sample of a frame is accepted at edge T. X[0] appears (valid_o=1) after edge T+1.
//   X[n] follows one cycle later per n. 32 consecutive valid cycles per frame.
//  Mapping: input position p (0..N-1) holds X[bitrev_LOG2N(p)]; output n is X[n].
//  Throughput: a frame needs >=N accepts and a drain takes exactly N cycles, so the write bank is always free when
//   written. Overflow is structurally impossible; no backpressure port.
//  Simultaneous events: a frame completes on the same edge the other bank's drain ends -> full set/clear handled
//   independently per bank, and the next drain starts on the following cycle.
//  Outputs when valid_o=0: data_out_r/i hold their last value; last_o=0.
// CONFIGURATION
//  FFT_REORDER_INDEX_EN defined: adds output port index_o [LOG2N-1:0].
//   index_o is registered alongside data_out_* and equals n (natural bin index) while valid_o=1; it is 0 at reset and when idle.
//  Not defined: the port is absent. All other behaviour is identical.
// TESTING
//  1 Single frame: after reset, p-th accept has data_in_r=p, data_in_i=-p, one per cycle ->
//    outputs from T+1 are r=0,16,8,24,4,20,...,15,31 (bitrev5(n)) with i=-r; last_o only on the 32nd; valid_o low after.
//  2 Gapped input: same frame with valid_i low every other cycle -> output identical to test 1; burst contiguous, starting 1 cycle after last accept.
//  3 Back-to-back: frames A (r=p) and B (r=100+p) streamed with no gap -> 64 contiguous valid_o cycles,
//    A then B in natural order; last_o at cycles 32 and 64.
//  4 Reset mid-write: drop rst after 10 samples, restart a full frame (r=200+p) -> only the new frame is output;
//    no valid_o from the partial one.
//  5 Reset mid-drain: assert rst at output n=5 -> valid_o=0, data_out=0 immediately (async); no further outputs until a new full frame.
//  6 FFT_REORDER_INDEX_EN defined, rerun test 1 -> index_o=0..31 aligned with valid_o, data_out_r==bitrev5(index_o).

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural-order bursts out.
// Define FFT_REORDER_INDEX_EN to add the index_o output port.
module fft_bitrev_reorder #(
    parameter int DATA_W = 19,
    parameter int N      = 32,
    parameter int LOG2N  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_in_r,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_out_r,
    output logic [DATA_W-1:0] data_out_i,
`ifdef FFT_REORDER_INDEX_EN
    output logic [LOG2N-1:0]  index_o,
`endif
    output logic              last_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int k = 0; k < LOG2N; k++) begin
            r[k] = a[LOG2N-1-k];
        end
        return r;
    endfunction

    logic [2*DATA_W-1:0] mem [2*N];

    logic [LOG2N-1:0] wr_cnt;
    logic             wr_bank;
    logic             wr_done;
    logic [1:0]       full;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;

    state_t           state;
    state_t           state_nx;
    logic             rd_bank;
    logic             rd_bank_nx;
    logic [LOG2N-1:0] rd_cnt;
    logic [LOG2N-1:0] rd_cnt_nx;
    logic             go;
    logic             sel;
    logic             rd_last;

    assign wr_done = valid_i && (wr_cnt == CNT_MAX);

    // Buffer RAM is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            mem[{wr_bank, bitrev(wr_cnt)}] <= {data_in_r, data_in_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (valid_i) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    always_comb begin
        full_set = '0;
        if (wr_done) begin
            full_set[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= '0;
        end else begin
            full <= (full & ~full_clr) | full_set;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            state   <= state_nx;
            rd_bank <= rd_bank_nx;
            rd_cnt  <= rd_cnt_nx;
        end
    end

    // IDLE emits X[0] in the same cycle it sees a full bank, so the
    // burst starts one edge after the frame's final accept.
    always_comb begin
        state_nx   = state;
        rd_bank_nx = rd_bank;
        rd_cnt_nx  = rd_cnt;
        go         = 1'b0;
        sel        = rd_bank;
        full_clr   = '0;
        rd_last    = (rd_cnt == CNT_MAX);
        unique case (state)
            IDLE: begin
                if (|full) begin
                    go  = 1'b1;
                    sel = (&full) ? wr_bank : full[1];
                end
            end
            DRAIN: begin
                go = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (go) begin
            rd_cnt_nx  = rd_cnt + 1'b1;
            rd_bank_nx = sel;
            state_nx   = DRAIN;
            if (rd_last) begin
                full_clr[sel] = 1'b1;
                if (full[~sel]) begin
                    rd_bank_nx = ~sel;
                end else begin
                    state_nx = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
        end else begin
            valid_o <= go;
            last_o  <= go && rd_last;
            if (go) begin
                {data_out_r, data_out_i} <= mem[{sel, rd_cnt}];
            end
        end
    end

`ifdef FFT_REORDER_INDEX_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_o <= '0;
        end else begin
            index_o <= go ? rd_cnt : '0;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: single, gapped, back-to-back frames
// and resets during write and during drain.
module tb_fft_bitrev_reorder;

    localparam int DATA_W = 19;
    localparam int N      = 32;
    localparam int LOG2N  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              valid_i = 1'b0;
    logic [DATA_W-1:0] data_in_r = '0;
    logic [DATA_W-1:0] data_in_i = '0;
    logic              valid_o;
    logic [DATA_W-1:0] data_out_r;
    logic [DATA_W-1:0] data_out_i;
    logic              last_o;
`ifdef FFT_REORDER_INDEX_EN
    logic [LOG2N-1:0]  index_o;
`endif

    fft_bitrev_reorder #(
        .DATA_W(DATA_W),
        .N(N),
        .LOG2N(LOG2N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_i(valid_i),
        .data_in_r(data_in_r),
        .data_in_i(data_in_i),
        .valid_o(valid_o),
        .data_out_r(data_out_r),
        .data_out_i(data_out_i),
`ifdef FFT_REORDER_INDEX_EN
        .index_o(index_o),
`endif
        .last_o(last_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Natural bin n is found at input position bitrev5(n).
    int brv [N] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                    1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

    int asserts = 0;
    int fails   = 0;
    int last_acc = 0;

    int q_r [$];
    int q_i [$];
    int q_last [$];
    int q_cyc [$];
    int q_idx [$];

    always @(negedge clk) begin
        if (valid_o) begin
            q_r.push_back(int'($signed(data_out_r)));
            q_i.push_back(int'($signed(data_out_i)));
            q_last.push_back(int'(last_o));
            q_cyc.push_back(cyc);
`ifdef FFT_REORDER_INDEX_EN
            q_idx.push_back(int'(index_o));
`else
            q_idx.push_back(0);
`endif
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        asserts++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_r.delete();
        q_i.delete();
        q_last.delete();
        q_cyc.delete();
        q_idx.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int base, input int count, input bit gap);
        for (int p = 0; p < count; p++) begin
            @(posedge clk);
            #1;
            valid_i   = 1'b1;
            data_in_r = DATA_W'(base + p);
            data_in_i = DATA_W'(-(base + p));
            if (gap && p < count - 1) begin
                @(posedge clk);
                #1;
                valid_i = 1'b0;
            end
        end
    endtask

    task automatic finish_frame();
        @(posedge clk);
        #1;
        last_acc = cyc;
        valid_i  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int off, input int base);
        if (q_r.size() >= off + N) begin
            for (int k = 0; k < N; k++) begin
                check({tag, "_r"}, q_r[off+k], base + brv[k]);
                check({tag, "_i"}, q_i[off+k], -(base + brv[k]));
                check({tag, "_last"}, q_last[off+k], (k == N - 1) ? 1 : 0);
                check({tag, "_contig"}, q_cyc[off+k], q_cyc[off] + k);
`ifdef FFT_REORDER_INDEX_EN
                check({tag, "_idx"}, q_idx[off+k], k);
`endif
            end
        end
    endtask

    initial begin
        wait_cycles(3);
        check("rst_valid", int'(valid_o), 0);
        check("rst_last", int'(last_o), 0);
        check("rst_dr", int'(data_out_r), 0);
        check("rst_di", int'(data_out_i), 0);
`ifdef FFT_REORDER_INDEX_EN
        check("rst_idx", int'(index_o), 0);
`endif
        rst = 1'b1;
        wait_cycles(2);

        // single frame
        clear_q();
        send(0, N, 1'b0);
        finish_frame();
        wait_cycles(40);
        check("t1_count", q_r.size(), N);
        if (q_cyc.size() > 0) check("t1_latency", q_cyc[0], last_acc + 1);
        check_frame("t1", 0, 0);
        check("t1_valid_after", int'(valid_o), 0);
        check("t1_last_after", int'(last_o), 0);

        // gapped input
        clear_q();
        send(0, N, 1'b1);
        finish_frame();
        wait_cycles(40);
        check("t2_count", q_r.size(), N);
        if (q_cyc.size() > 0) check("t2_latency", q_cyc[0], last_acc + 1);
        check_frame("t2", 0, 0);

        // back-to-back frames
        clear_q();
        send(0, N, 1'b0);
        send(100, N, 1'b0);
        finish_frame();
        wait_cycles(80);
        check("t3_count", q_r.size(), 2 * N);
        check_frame("t3a", 0, 0);
        check_frame("t3b", N, 100);
        if (q_cyc.size() >= 2 * N) check("t3_join", q_cyc[N], q_cyc[N-1] + 1);
        if (q_cyc.size() > 0) check("t3_latency", q_cyc[q_cyc.size()-1], last_acc + N);

        // reset mid-write
        clear_q();
        send(50, 10, 1'b0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        rst = 1'b0;
        #3;
        rst = 1'b1;
        wait_cycles(40);
        check("t4_partial", q_r.size(), 0);
        send(200, N, 1'b0);
        finish_frame();
        wait_cycles(40);
        check("t4_count", q_r.size(), N);
        check_frame("t4", 0, 200);

        // reset mid-drain at output n=5
        clear_q();
        send(0, N, 1'b0);
        finish_frame();
        begin
            bit hit = 1'b0;
            for (int k = 0; k < 100 && !hit; k++) begin
                @(posedge clk);
                #2;
                if (valid_o && int'(data_out_r) == brv[5]) hit = 1'b1;
            end
            check("t5_reach_n5", int'(hit), 1);
        end
        rst = 1'b0;
        #1;
        check("t5_valid", int'(valid_o), 0);
        check("t5_dr", int'(data_out_r), 0);
        check("t5_di", int'(data_out_i), 0);
        check("t5_last", int'(last_o), 0);
        check("t5_before", q_r.size(), 5);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(40);
        check("t5_quiet", q_r.size(), 5);
        send(300, N, 1'b0);
        finish_frame();
        wait_cycles(40);
        check("t5_count", q_r.size(), 5 + N);
        check_frame("t5", 5, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
